// File: rtl/cache_ctrl_pf.sv
// Set-associative write-back / write-allocate cache controller with tree PLRU
// replacement, next-N-line prefetch and hit/miss/prefetch counters.
module cache_ctrl_pf #(
  parameter int unsigned WAYS       = 4,
  parameter int unsigned SETS       = 16,
  parameter int unsigned LINE_BYTES = 32,
  parameter int unsigned PF_EN      = 1,
  parameter int unsigned PF_DIST    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             ufp_addr,
  input  logic [3:0]              ufp_rmask,
  input  logic [3:0]              ufp_wmask,
  input  logic [31:0]             ufp_wdata,
  output logic [31:0]             ufp_rdata,
  output logic                    ufp_resp,
  output logic [31:0]             dfp_addr,
  output logic                    dfp_read,
  output logic                    dfp_write,
  output logic [8*LINE_BYTES-1:0] dfp_wdata,
  input  logic [8*LINE_BYTES-1:0] dfp_rdata,
  input  logic                    dfp_resp,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count,
  output logic [31:0]             pf_count
);

  localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = 32 - OFF_W - IDX_W;
  localparam int unsigned WAY_W  = $clog2(WAYS);
  localparam int unsigned LINE_W = 8 * LINE_BYTES;
  localparam int unsigned WSEL_W = OFF_W - 2;
  localparam int unsigned TREE_W = WAYS - 1;

  typedef enum logic [2:0] {
    StIdle, StCompare, StWriteback, StAllocate, StPrefetch, StPfFill
  } state_e;

  state_e             state_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [3:0]         wmask_q;
  logic               is_write_q;
  logic               filled_q;
  logic [WAY_W-1:0]   victim_q;

  logic [TAG_W-1:0]   tag_arr  [SETS][WAYS];
  logic [LINE_W-1:0]  data_arr [SETS][WAYS];
  logic [WAYS-1:0]    valid_q  [SETS];
  logic [WAYS-1:0]    dirty_q  [SETS];
  logic [TREE_W-1:0]  plru_q   [SETS];

  // Tree walk: node n has children 2n+1 (bit 0) and 2n+2 (bit 1). The decision taken at
  // tree level l supplies way bit l, so the root splits even ways from odd ways.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [TREE_W-1:0] tree);
    int unsigned       node;
    logic [TREE_W-1:0] t;
    logic [WAY_W-1:0]  way;
    node = 0;
    way  = '0;
    for (int l = 0; l < WAY_W; l++) begin
      t      = tree >> node;
      way[l] = t[0];
      node   = 2 * node + (t[0] ? 2 : 1);
    end
    return way;
  endfunction

  // Point every node on the path of 'way' away from it, making it most recently used.
  function automatic logic [TREE_W-1:0] plru_touch(input logic [TREE_W-1:0] tree,
                                                   input logic [WAY_W-1:0]  way);
    int unsigned       node;
    logic [TREE_W-1:0] res;
    logic [TREE_W-1:0] m;
    node = 0;
    res  = tree;
    for (int l = 0; l < WAY_W; l++) begin
      m = TREE_W'(1) << node;
      if (way[l]) res = res & ~m;
      else        res = res | m;
      node = 2 * node + (way[l] ? 2 : 1);
    end
    return res;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] mask);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = mask[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    return res;
  endfunction

  logic [31:0]       req_line, pf_line, look_line;
  logic [IDX_W-1:0]  look_idx;
  logic [TAG_W-1:0]  look_tag;
  logic [WSEL_W-1:0] wsel;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  victim;
  logic [31:0]       hit_word;
  logic              fill_we, word_we;

  assign req_line  = {addr_q[31:OFF_W], {OFF_W{1'b0}}};
  assign pf_line   = req_line + 32'(PF_DIST * LINE_BYTES);
  // Prefetch states probe the target line; every other state probes the demand line.
  assign look_line = (state_q == StPrefetch || state_q == StPfFill) ? pf_line : req_line;
  assign look_idx  = look_line[OFF_W +: IDX_W];
  assign look_tag  = look_line[31 -: TAG_W];
  assign wsel      = addr_q[2 +: WSEL_W];
  assign hit_word  = data_arr[look_idx][hit_way][{wsel, 5'b0} +: 32];
  assign fill_we   = (state_q == StAllocate || state_q == StPfFill) && dfp_resp;
  assign word_we   = (state_q == StCompare) && hit && is_write_q;

  logic unused_bits;
  assign unused_bits = ^{addr_q[1:0], look_line[OFF_W-1:0]};

  // Tag lookup and victim selection for the probed set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    victim  = plru_victim(plru_q[look_idx]);
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[look_idx][w] && tag_arr[look_idx][w] == look_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    // Descending scan so the lowest-index invalid way wins.
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!valid_q[look_idx][w]) victim = WAY_W'(w);
    end
  end

  // Tag/data storage: line installs on fill responses, byte merges on write hits.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_arr[look_idx][victim_q] <= dfp_rdata;
      tag_arr[look_idx][victim_q]  <= look_tag;
    end else if (word_we) begin
      data_arr[look_idx][hit_way][{wsel, 5'b0} +: 32] <= merge_bytes(hit_word, wdata_q, wmask_q);
    end
  end

  // Controller FSM with registered port outputs and per-set valid/dirty/PLRU state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      is_write_q <= 1'b0;
      filled_q   <= 1'b0;
      victim_q   <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
      ufp_rdata  <= '0;
      ufp_resp   <= 1'b0;
      dfp_addr   <= '0;
      dfp_read   <= 1'b0;
      dfp_write  <= 1'b0;
      dfp_wdata  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      pf_count   <= '0;
    end else begin
      ufp_resp <= 1'b0;
      case (state_q)
        StIdle: begin
          if (|(ufp_rmask | ufp_wmask)) begin
            addr_q     <= ufp_addr;
            wdata_q    <= ufp_wdata;
            wmask_q    <= ufp_wmask;
            is_write_q <= |ufp_wmask;
            filled_q   <= 1'b0;
            state_q    <= StCompare;
          end
        end
        StCompare: begin
          if (hit) begin
            ufp_resp         <= 1'b1;
            ufp_rdata        <= hit_word;
            plru_q[look_idx] <= plru_touch(plru_q[look_idx], hit_way);
            if (is_write_q) dirty_q[look_idx][hit_way] <= 1'b1;
            // The hit that follows a fill finishes a miss and is not counted again.
            if (!filled_q) hit_count <= hit_count + 32'd1;
            state_q <= (filled_q && PF_EN != 0) ? StPrefetch : StIdle;
          end else begin
            miss_count <= miss_count + 32'd1;
            victim_q   <= victim;
            if (dirty_q[look_idx][victim]) begin
              dfp_write <= 1'b1;
              dfp_addr  <= {tag_arr[look_idx][victim], look_idx, {OFF_W{1'b0}}};
              dfp_wdata <= data_arr[look_idx][victim];
              state_q   <= StWriteback;
            end else begin
              dfp_read <= 1'b1;
              dfp_addr <= req_line;
              state_q  <= StAllocate;
            end
          end
        end
        StWriteback: begin
          if (dfp_resp) begin
            dfp_write                   <= 1'b0;
            dirty_q[look_idx][victim_q] <= 1'b0;
            dfp_read                    <= 1'b1;
            dfp_addr                    <= req_line;
            state_q                     <= StAllocate;
          end
        end
        StAllocate: begin
          if (dfp_resp) begin
            dfp_read                    <= 1'b0;
            valid_q[look_idx][victim_q] <= 1'b1;
            dirty_q[look_idx][victim_q] <= 1'b0;
            filled_q                    <= 1'b1;
            state_q                     <= StCompare;
          end
        end
        StPrefetch: begin
          // Prefetch never evicts dirty data; it is simply dropped instead.
          if (hit || dirty_q[look_idx][victim]) begin
            state_q <= StIdle;
          end else begin
            victim_q <= victim;
            dfp_read <= 1'b1;
            dfp_addr <= pf_line;
            state_q  <= StPfFill;
          end
        end
        StPfFill: begin
          if (dfp_resp) begin
            dfp_read                    <= 1'b0;
            valid_q[look_idx][victim_q] <= 1'b1;
            dirty_q[look_idx][victim_q] <= 1'b0;
            plru_q[look_idx]            <= plru_touch(plru_q[look_idx], victim_q);
            pf_count                    <= pf_count + 32'd1;
            state_q                     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl_pf.sv
// Directed bench for cache_ctrl_pf: one instance without prefetch, one with, sharing a
// simple memory model whose word at byte address a reads as a ^ 32'hDEADAEEB.
module tb_cache_ctrl_pf;

  localparam int unsigned LW = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          sel;  // 0 = no-prefetch instance, 1 = prefetch instance
  logic [31:0]   addr, wdata;
  logic [3:0]    rmask, wmask;
  logic [LW-1:0] m_rdata;
  logic          m_resp;

  logic [3:0]    np_rmask, np_wmask, pf_rmask, pf_wmask;
  logic [31:0]   np_rdata, pf_rdata, np_daddr, pf_daddr;
  logic          np_resp, pf_resp, np_dread, pf_dread, np_dwrite, pf_dwrite;
  logic          np_dresp, pf_dresp;
  logic [LW-1:0] np_dwdata, pf_dwdata;
  logic [31:0]   np_hits, pf_hits, np_miss, pf_miss, np_pfc, pf_pfc;

  assign np_rmask = sel ? 4'd0 : rmask;
  assign np_wmask = sel ? 4'd0 : wmask;
  assign pf_rmask = sel ? rmask : 4'd0;
  assign pf_wmask = sel ? wmask : 4'd0;
  assign np_dresp = m_resp & ~sel;
  assign pf_dresp = m_resp & sel;

  cache_ctrl_pf #(.WAYS(4), .SETS(16), .LINE_BYTES(32), .PF_EN(0), .PF_DIST(1)) u_np (
    .clk(clk), .rst(rst), .ufp_addr(addr), .ufp_rmask(np_rmask), .ufp_wmask(np_wmask),
    .ufp_wdata(wdata), .ufp_rdata(np_rdata), .ufp_resp(np_resp), .dfp_addr(np_daddr),
    .dfp_read(np_dread), .dfp_write(np_dwrite), .dfp_wdata(np_dwdata), .dfp_rdata(m_rdata),
    .dfp_resp(np_dresp), .hit_count(np_hits), .miss_count(np_miss), .pf_count(np_pfc)
  );

  cache_ctrl_pf #(.WAYS(4), .SETS(16), .LINE_BYTES(32), .PF_EN(1), .PF_DIST(1)) u_pf (
    .clk(clk), .rst(rst), .ufp_addr(addr), .ufp_rmask(pf_rmask), .ufp_wmask(pf_wmask),
    .ufp_wdata(wdata), .ufp_rdata(pf_rdata), .ufp_resp(pf_resp), .dfp_addr(pf_daddr),
    .dfp_read(pf_dread), .dfp_write(pf_dwrite), .dfp_wdata(pf_dwdata), .dfp_rdata(m_rdata),
    .dfp_resp(pf_dresp), .hit_count(pf_hits), .miss_count(pf_miss), .pf_count(pf_pfc)
  );

  logic [31:0]   rdata, d_addr, hits, misses, pfs;
  logic          resp, d_read, d_write;
  logic [LW-1:0] d_wdata;
  assign rdata   = sel ? pf_rdata  : np_rdata;
  assign resp    = sel ? pf_resp   : np_resp;
  assign d_addr  = sel ? pf_daddr  : np_daddr;
  assign d_read  = sel ? pf_dread  : np_dread;
  assign d_write = sel ? pf_dwrite : np_dwrite;
  assign d_wdata = sel ? pf_dwdata : np_dwdata;
  assign hits    = sel ? pf_hits   : np_hits;
  assign misses  = sel ? pf_miss   : np_miss;
  assign pfs     = sel ? pf_pfc    : np_pfc;

  function automatic logic [LW-1:0] line_data(input logic [31:0] a);
    logic [LW-1:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = (a + 32'(4 * i)) ^ 32'hDEADAEEB;
    return l;
  endfunction

  // Memory model: answers each request three cycles after it is seen, logging traffic.
  int          m_cnt, rd_cnt, wr_cnt;
  logic [31:0] last_rd, last_wr, last_wr_word;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt   <= 0;
      m_resp  <= 1'b0;
      m_rdata <= '0;
      rd_cnt  <= 0;
      wr_cnt  <= 0;
      last_rd <= '0;
      last_wr <= '0;
      last_wr_word <= '0;
    end else if (m_resp) begin
      m_resp <= 1'b0;
    end else if (d_read || d_write) begin
      if (m_cnt == 2) begin
        m_cnt   <= 0;
        m_resp  <= 1'b1;
        m_rdata <= line_data(d_addr);
        if (d_read) begin
          rd_cnt  <= rd_cnt + 1;
          last_rd <= d_addr;
        end else begin
          wr_cnt       <= wr_cnt + 1;
          last_wr      <= d_addr;
          last_wr_word <= d_wdata[31:0];
        end
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle; lat counts cycles from presentation to ufp_resp.
  task automatic do_req(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd);
    @(negedge clk);
    addr = a; rmask = rm; wmask = wm; wdata = wd;
    @(posedge clk); #1;
    rmask = 4'd0; wmask = 4'd0;
    lat = 1;
    while (resp !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (resp !== 1'b1) check("resp_timeout", 32'(resp), 32'd1);
    rd = rdata;
  endtask

  task automatic settle();
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_resp", 32'(resp), 32'd0);
    check("rst_dfp_read", 32'(d_read), 32'd0);
    check("rst_dfp_write", 32'(d_write), 32'd0);
    check("rst_counts", hits | misses | pfs, 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  int          lat;
  logic [31:0] rd;

  initial begin
    rst = 1'b0; sel = 1'b0; addr = '0; wdata = '0; rmask = '0; wmask = '0;

    // Cold read miss then repeated hit.
    do_reset();
    do_req(32'h0000_1004, 4'hF, 4'h0, 32'h0, lat, rd);
    check("t1_rdata", rd, 32'hDEADBEEF);
    check("t1_miss", misses, 32'd1);
    check("t1_hits", hits, 32'd0);
    check("t1_rd_addr", last_rd, 32'h0000_1000);
    check("t1_rd_cnt", 32'(rd_cnt), 32'd1);
    check("t1_no_wr", 32'(wr_cnt), 32'd0);
    settle();
    do_req(32'h0000_1004, 4'hF, 4'h0, 32'h0, lat, rd);
    check("t2_latency", 32'(lat), 32'd2);
    check("t2_rdata", rd, 32'hDEADBEEF);
    check("t2_hits", hits, 32'd1);
    check("t2_miss", misses, 32'd1);
    settle();
    check("t2_no_traffic", 32'(rd_cnt + wr_cnt), 32'd1);

    // Dirty way 0 of set 0 evicted by the fifth line.
    do_reset();
    do_req(32'h0000_0000, 4'h0, 4'h1, 32'h0000_0055, lat, rd); settle();
    do_req(32'h0000_0200, 4'hF, 4'h0, 32'h0, lat, rd); settle();
    do_req(32'h0000_0400, 4'hF, 4'h0, 32'h0, lat, rd); settle();
    do_req(32'h0000_0600, 4'hF, 4'h0, 32'h0, lat, rd); settle();
    check("t3_no_wb_yet", 32'(wr_cnt), 32'd0);
    do_req(32'h0000_0800, 4'hF, 4'h0, 32'h0, lat, rd);
    check("t3_wb_cnt", 32'(wr_cnt), 32'd1);
    check("t3_wb_addr", last_wr, 32'h0000_0000);
    check("t3_wb_word0", last_wr_word, 32'hDEADAE55);
    check("t3_rd_addr", last_rd, 32'h0000_0800);
    check("t3_rdata", rd, 32'hDEADA6EB);
    check("t3_miss", misses, 32'd5);
    settle();

    // PLRU in set 3: ways 0..2 re-read, so way 3 (dirty) is the victim.
    do_reset();
    do_req(32'h0000_0060, 4'hF, 4'h0, 32'h0, lat, rd); settle();
    do_req(32'h0000_0260, 4'hF, 4'h0, 32'h0, lat, rd); settle();
    do_req(32'h0000_0460, 4'hF, 4'h0, 32'h0, lat, rd); settle();
    do_req(32'h0000_0660, 4'h0, 4'hF, 32'h1234_5678, lat, rd); settle();
    do_req(32'h0000_0060, 4'hF, 4'h0, 32'h0, lat, rd); settle();
    do_req(32'h0000_0260, 4'hF, 4'h0, 32'h0, lat, rd); settle();
    do_req(32'h0000_0460, 4'hF, 4'h0, 32'h0, lat, rd); settle();
    check("t4_hits", hits, 32'd3);
    do_req(32'h0000_0860, 4'hF, 4'h0, 32'h0, lat, rd);
    check("t4_wb_addr", last_wr, 32'h0000_0660);
    check("t4_wb_word0", last_wr_word, 32'h1234_5678);
    check("t4_rdata", rd, 32'hDEADA68B);
    check("t4_miss", misses, 32'd5);
    settle();

    // Next-line prefetch, including address wrap.
    sel = 1'b1;
    do_reset();
    do_req(32'h0000_0100, 4'hF, 4'h0, 32'h0, lat, rd);
    check("t5_rdata", rd, 32'hDEADAFEB);
    settle();
    check("t5_pf_addr", last_rd, 32'h0000_0120);
    check("t5_pf_cnt", pfs, 32'd1);
    check("t5_rd_cnt", 32'(rd_cnt), 32'd2);
    do_req(32'h0000_0120, 4'hF, 4'h0, 32'h0, lat, rd);
    check("t5_pf_hit_lat", 32'(lat), 32'd2);
    check("t5_pf_hit_data", rd, 32'hDEADAFCB);
    check("t5_hits", hits, 32'd1);
    settle();
    check("t5_hit_no_pf", 32'(rd_cnt), 32'd2);
    do_req(32'hFFFF_FFE0, 4'hF, 4'h0, 32'h0, lat, rd);
    check("t5_wrap_rdata", rd, 32'h2152_510B);
    settle();
    check("t5_wrap_pf_addr", last_rd, 32'h0000_0000);
    check("t5_wrap_pf_cnt", pfs, 32'd2);
    check("t5_wrap_miss", misses, 32'd2);

    // Reset while a fill is outstanding.
    sel = 1'b0;
    do_reset();
    do_req(32'h0000_0040, 4'hF, 4'h0, 32'h0, lat, rd);
    check("t6_first_rdata", rd, 32'hDEADAEAB);
    settle();
    @(negedge clk);
    addr = 32'h0000_2000; rmask = 4'hF;
    @(posedge clk); #1;
    rmask = 4'd0;
    for (int i = 0; i < 20 && d_read !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    check("t6_alloc_read", 32'(d_read), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("t6_read_dropped", 32'(d_read), 32'd0);
    check("t6_miss_cleared", misses, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    do_req(32'h0000_0040, 4'hF, 4'h0, 32'h0, lat, rd);
    check("t6_again_miss", misses, 32'd1);
    check("t6_again_hits", hits, 32'd0);
    check("t6_again_rd_cnt", 32'(rd_cnt), 32'd1);
    check("t6_again_rdata", rd, 32'hDEADAEAB);
    settle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_ctrl_pf.md
Name: cache_ctrl_pf

Overview:
- Parametrised N-way set-associative, write-back, write-allocate cache controller with internal tag, data, valid, dirty and PLRU arrays.
- Serves a 32-bit CPU-side port (ufp) and a line-wide memory-side port (dfp).
- Extends the 4-way fixed-PLRU cache logic with generic tree PLRU, parametrised geometry, configurable next-N-line prefetch and performance counters.
- Sits between the core's fetch/LSU arbiter and the memory/burst adapter.

Parameters:
WAYS, 4, associativity; power of 2, 2..16
SETS, 16, sets; power of 2
LINE_BYTES, 32, line size in bytes; power of 2, 8..64
PF_EN, 1, 1 enables the prefetch state
PF_DIST, 1, prefetch target = demand line + PF_DIST lines (1..4)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
ufp_addr  in  32  byte address of request
ufp_rmask  in  4  read byte mask; nonzero = read
ufp_wmask  in  4  write byte mask; nonzero = write
ufp_wdata  in  32  write data
ufp_rdata  out  32  read data, valid with ufp_resp
ufp_resp  out  1  one-cycle completion pulse
dfp_addr  out  32  line-aligned memory address
dfp_read  out  1  line read request, held until dfp_resp
dfp_write  out  1  line write request, held until dfp_resp
dfp_wdata  out  8*LINE_BYTES  writeback line
dfp_rdata  in  8*LINE_BYTES  fill line, valid with dfp_resp
dfp_resp  in  1  memory completion pulse
hit_count  out  32  demand hits, wrapping
miss_count  out  32  demand misses, wrapping
pf_count  out  32  prefetch fills installed, wrapping

Behaviour:
- Address split: offset = low log2(LINE_BYTES) bits; index = next log2(SETS) bits; tag = remainder. Word select = offset[msb:2].
- Reset (rst=0, async): state IDLE; all valid, dirty and PLRU bits cleared; counters 0; ufp_resp, dfp_read, dfp_write = 0.
- Reset mid-transaction: the FSM aborts immediately. No partial line install. Any pending dfp request is dropped.
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE, PREFETCH, PF_FILL.
- IDLE: when rmask|wmask is nonzero, latch addr/masks/wdata and go to COMPARE. Upstream may change inputs after this cycle. If both masks are nonzero, the request is treated as a write.
- COMPARE, hit: ufp_resp=1 this cycle and hit_count++.
  - Read: ufp_rdata = hit word, full 32 bits regardless of rmask.
  - Write: merge bytes per wmask and set dirty. ufp_rdata is don't-care.
  - PLRU is updated to mark the hit way MRU.
  - Next state IDLE, or PREFETCH if a miss fill occurred for this request and PF_EN=1.
  - Hit latency is 2 cycles from request presentation.
- COMPARE, miss: miss_count++ and victim chosen. Victim = lowest-index invalid way, else the tree-PLRU victim (WAYS-1 bits per set, 0 = go left).
  - Victim dirty: go to WRITEBACK.
  - Victim clean: go to ALLOCATE.
- WRITEBACK: dfp_write=1, dfp_addr = {victim tag, index, 0}, dfp_wdata = victim line. On dfp_resp, clear dirty and go to ALLOCATE.
- ALLOCATE: dfp_read=1, dfp_addr = demand line address. On dfp_resp, install line (valid=1, dirty=0, tag) and return to COMPARE. The guaranteed hit there completes the request; it counts as a miss only, not a hit.
- PREFETCH (one cycle): target = (demand line address + PF_DIST*LINE_BYTES) mod 2^32.
  - Target already present: return to IDLE.
  - Victim of target set is dirty: drop the prefetch and return to IDLE. Prefetch never writes back.
  - Otherwise go to PF_FILL.
- PF_FILL: dfp_read=1 on the target address. On dfp_resp, install clean, mark PLRU MRU, pf_count++, and return to IDLE. New ufp requests are not accepted until IDLE.
- Prefetch never issues while a demand miss is outstanding. Prefetch is never triggered by a prefetch fill or by a hit.
- dfp_read and dfp_write are never both 1. dfp requests deassert in the cycle after dfp_resp.
- Counters wrap at 2^32.

Test Plan:
1. Reset; read 0x0000_1004, PF_EN=0 -> miss_count=1; dfp_read at 0x0000_1000; fill word1=0xDEADBEEF -> ufp_resp with ufp_rdata=0xDEADBEEF; no dfp_write.
2. Repeat the same read -> ufp_resp exactly 2 cycles after presentation, hit_count=1, no dfp activity.
3. WAYS=4, SETS=16, PF_EN=0. Write wmask=0001, data 0x55 to 0x0000_0000. Then read 4 further lines mapping to set 0 (0x200, 0x400, 0x600, 0x800) -> fifth miss evicts way 0. dfp_write at 0x0000_0000 with byte0=0x55, then dfp_read at 0x800.
4. PLRU: fill 4 ways of set 3, re-read ways 0,1,2, then miss -> way 3 replaced.
5. PF_EN=1, PF_DIST=1: read miss at 0x100 -> after the demand ufp_resp, dfp_read at 0x120; pf_count=1. Read 0x120 -> hit, no dfp traffic. Read 0xFFFF_FFE0 miss -> prefetch address wraps to 0x0000_0000.
6. Assert rst low while dfp_read is high in ALLOCATE -> dfp_read=0 immediately, all lines invalid, and the next request misses.
